// File: rtl/parity_link_pkg.sv
// rtl/parity_link_pkg.sv - state encoding and frame width shared by both ends of the parity link
package parity_link_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - single-bit XOR accumulator with synchronous clear, load and enable
module parity_acc (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);

  logic r_acc;

  // Load wins over enable so a new frame can restart mid-stream.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_bit;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_bit;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - serial LSB-first parity receiver with valid/ready output; PARITY_RX_ODD_EN selects odd parity
module serial_parity_rx
  import parity_link_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  input  logic             i_in_bit,
  input  logic             i_in_start,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_err
);

  localparam int COUNT_W = $clog2(WIDTH);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_err;

  logic w_accept;
  logic w_load;
  logic w_en;
  logic w_acc;
  logic w_final;
  logic w_err;

  assign o_in_ready  = (r_state != HOLD);
  assign o_out_valid = (r_state == HOLD);
  assign o_out_data  = r_out_data;
  assign o_out_err   = r_out_err;

  assign w_accept = i_in_valid && o_in_ready;
  assign w_load   = w_accept && i_in_start;
  assign w_en     = w_accept && !i_in_start && (r_state == DATA || r_state == PARITY);
  assign w_final  = w_acc ^ i_in_bit;

`ifdef PARITY_RX_ODD_EN
  assign w_err = ~w_final;
`else
  assign w_err = w_final;
`endif

  parity_acc u_acc (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_load (w_load),
    .i_en   (w_en),
    .i_bit  (i_in_bit),
    .o_acc  (w_acc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_load) w_state_nxt = DATA;
        else if (w_en && r_count == LAST) w_state_nxt = PARITY;
      end
      PARITY: begin
        if (w_load) w_state_nxt = DATA;
        else if (w_en) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (i_out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A start bit in any accepting state restarts the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_shift    <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shift <= {{(WIDTH-1){1'b0}}, i_in_bit};
        r_count <= COUNT_W'(1);
      end else if (w_en && r_state == DATA) begin
        r_shift[r_count] <= i_in_bit;
        r_count <= (r_count == LAST) ? '0 : r_count + COUNT_W'(1);
      end else if (w_en && r_state == PARITY) begin
        r_out_data <= r_shift;
        r_out_err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - self-checking bench for serial_parity_rx with a frame-level reference model
module tb_serial_parity_rx;

  localparam int W = 8;
`ifdef PARITY_RX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  localparam logic ERR_EVEN_ONES = ODD;
  localparam logic ERR_ODD_ONES  = ~ODD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_start = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  logic [W:0]   m_buf;
  int           m_nbits = 0;
  logic         m_hold = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_err = 1'b0;

  always #5 clk = ~clk;

  serial_parity_rx #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_bit    (in_bit),
    .i_in_start  (in_start),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_err   (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect accepted bits, decide on the full frame at once.
  always @(posedge clk) begin
    if (rst) begin
      m_nbits = 0;
      m_hold  = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      if (in_start) begin
        m_buf    = '0;
        m_buf[0] = in_bit;
        m_nbits  = 1;
      end else if (m_nbits > 0) begin
        m_buf[m_nbits] = in_bit;
        m_nbits++;
        if (m_nbits == W + 1) begin
          m_data  = m_buf[W-1:0];
          m_err   = (^m_buf) ^ ODD;
          m_hold  = 1'b1;
          m_nbits = 0;
          n_frames++;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
      check("in_ready", {31'b0, in_ready}, {31'b0, ~m_hold});
      check("out_data", {24'b0, out_data}, {24'b0, m_data});
      check("out_err", {31'b0, out_err}, {31'b0, m_err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st, input int gap);
    in_valid = 1'b1;
    in_bit   = b;
    in_start = st;
    cyc();
    in_valid = 1'b0;
    in_start = 1'b0;
    for (int g = 0; g < gap; g++) cyc();
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input int maxgap);
    send_bit(d[0], 1'b1, (maxgap > 0) ? 1 : 0);
    for (int i = 1; i < W; i++) send_bit(d[i], 1'b0, (maxgap > 0) ? 1 + (i % maxgap) : 0);
    send_bit(p, 1'b0, 0);
  endtask

  task automatic pin_frame(input string name, input logic [W-1:0] d, input logic e);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_data"}, {24'b0, out_data}, {24'b0, d});
    check({name, "_err"}, {31'b0, out_err}, {31'b0, e});
  endtask

  task automatic pin_reset(input string name);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, "_ready"}, {31'b0, in_ready}, 32'd1);
    check({name, "_data"}, {24'b0, out_data}, 32'd0);
    check({name, "_err"}, {31'b0, out_err}, 32'd0);
  endtask

  initial begin
    int frames_before;
    cyc();
    cyc();
    rst = 1'b0;
    pin_reset("reset");

    send_frame(8'hA5, 1'b0, 0);
    pin_frame("a5", 8'hA5, ERR_EVEN_ONES);
    cyc();
    check("a5_released", {31'b0, out_valid}, 32'd0);

    send_frame(8'h01, 1'b0, 0);
    pin_frame("x01", 8'h01, ERR_ODD_ONES);
    cyc();

    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bit   = i[0];
      in_start = (i == 0 || i == 3);
      check("3c_blocked_ready", {31'b0, in_ready}, 32'd0);
      pin_frame("3c_hold", 8'h3C, ERR_EVEN_ONES);
      cyc();
    end
    in_valid  = 1'b0;
    in_start  = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("3c_ready_after", {31'b0, in_ready}, 32'd1);
    check("3c_valid_after", {31'b0, out_valid}, 32'd0);

    send_frame(8'hFF, 1'b0, 3);
    pin_frame("ff_gaps", 8'hFF, ERR_EVEN_ONES);
    cyc();

    frames_before = n_frames;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 0);
    pin_frame("5a_restart", 8'h5A, ERR_EVEN_ONES);
    check("5a_single", n_frames - frames_before, 32'd1);
    cyc();

    send_bit(1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pin_reset("rst_mid");

    out_ready = 1'b0;
    send_frame(8'h96, 1'b0, 0);
    pin_frame("96_hold", 8'h96, ERR_EVEN_ONES);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    pin_reset("rst_hold");

    send_frame(8'hC3, 1'b0, 0);
    pin_frame("c3", 8'hC3, ERR_EVEN_ONES);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
